bus_datapath_core: RTL and testbench

- Parametrised successor to the single-bus CPU datapath.
- Contains the register file, the Y and Z staging registers, in/out ports, the ALU and the bus-source encoding.
- Adds an internal micro-step sequencer, so one handshake runs a full register-to-register operation.
- Sits between the future control unit (which issues decoded ops) and memory/ports. Width, register count and immediate width are generic.

---
 rtl/bus_datapath_core_if.sv | 33 +++
 rtl/bus_datapath_core.sv | 259 +++++++++++++++++++++++++
 tb/tb_bus_datapath_core.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_datapath_core_if.sv
// Op handshake bundle between the control unit (master) and the datapath
// core (slave).
//   op_valid/op_ready : request handshake, op accepted when both are high
//   op_code, ra/rb/rc_sel, imm : decoded op fields, sampled at acceptance
//   done/err/result   : completion pulse, illegal-op flag, written/output value
interface bus_datapath_core_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int IMM_W = 19
);
  localparam int RW = $clog2(NREGS);

  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [RW-1:0]    ra_sel;
  logic [RW-1:0]    rb_sel;
  logic [RW-1:0]    rc_sel;
  logic [IMM_W-1:0] imm;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    output op_valid, op_code, ra_sel, rb_sel, rc_sel, imm,
    input  op_ready, done, err, result
  );

  modport slave (
    input  op_valid, op_code, ra_sel, rb_sel, rc_sel, imm,
    output op_ready, done, err, result
  );
endinterface

// File: rtl/bus_datapath_core.sv
// Single-bus datapath core: register file, Y/Z staging registers, in/out
// ports, ALU and an internal micro-step sequencer that runs one full
// register-to-register op per handshake.
// Ports:
//   clk, clr      : clock, synchronous active-low reset
//   op_if         : op handshake (slave side of bus_datapath_core_if)
//   inport_in     : input port, registered every cycle
//   outport_out   : output port register
//   bus_out       : internal bus value for trace (0 in IDLE)
//   dbg_sel/data  : combinational register file read
// Optional feature macro DP_HILO_EN: signed MUL (opcode 11) into HI/LO
// registers, exposed on hi_out/lo_out. Without it opcode 11 is illegal.
//
// state  | meaning
// IDLE   | op_ready high, waiting for op_valid
// S_Y    | Y <= R[rb] (wait cycle without Y load for IN/OUT)
// S_Z    | {Z_HI,Z_LO} <= ALU(Y, bus)
// S_WB   | destination loads bus, done (except MUL)
// S_WB2  | MUL only: HI <= Z_HI, done
// S_ERR  | illegal op: done + err, nothing written
module bus_datapath_core #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int IMM_W = 19
) (
  input  logic                     clk,
  input  logic                     clr,
  bus_datapath_core_if.slave       op_if,
  input  logic [WIDTH-1:0]         inport_in,
  output logic [WIDTH-1:0]         outport_out,
  output logic [WIDTH-1:0]         bus_out,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [WIDTH-1:0]         dbg_data
`ifdef DP_HILO_EN
  ,
  output logic [WIDTH-1:0]         hi_out,
  output logic [WIDTH-1:0]         lo_out
`endif
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4, OP_SHL = 4'd5, OP_ROR = 4'd6, OP_ROL = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8, OP_NOT = 4'd9, OP_ADDI = 4'd10, OP_MUL = 4'd11;
  localparam logic [3:0] OP_IN = 4'd12, OP_OUT = 4'd13;

  typedef enum logic [2:0] {IDLE, S_Y, S_Z, S_WB, S_WB2, S_ERR} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [RW-1:0]    ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] y_q, y_d, z_lo_q, z_lo_d;
  logic [WIDTH-1:0] inport_q, outport_q, outport_d, result_q, result_d;
`ifdef DP_HILO_EN
  logic [WIDTH-1:0]   z_hi_q, z_hi_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] prod;
`endif

  logic [WIDTH-1:0]   bus, imm_ext, alu_lo;
  logic [2*WIDTH-1:0] rot;
  logic [SW-1:0]      amt;
  logic               is_io, legal;

  assign imm_ext = {{(WIDTH-IMM_W){imm_q[IMM_W-1]}}, imm_q};
  assign is_io   = (op_q == OP_IN) || (op_q == OP_OUT);

  // Bus source select per micro-step.
  always_comb begin
    bus = '0;
    case (state_q)
      // ADDI with rb=0 treats R0 as zero (base-address form); IN/OUT idle the bus.
      S_Y:     if (!is_io && !(op_q == OP_ADDI && rb_q == '0)) bus = regs_q[rb_q];
      S_Z:     bus = (op_q == OP_ADDI) ? imm_ext : regs_q[rc_q];
      S_WB: begin
        case (op_q)
          OP_IN:   bus = inport_q;
          OP_OUT:  bus = regs_q[ra_q];
          default: bus = z_lo_q;
        endcase
      end
`ifdef DP_HILO_EN
      S_WB2:   bus = z_hi_q;
`endif
      default: bus = '0;
    endcase
  end

  always_comb begin
    alu_lo = '0;
    rot    = '0;
    amt    = bus[SW-1:0];
`ifdef DP_HILO_EN
    prod   = '0;
`endif
    case (op_q)
      OP_ADD:  alu_lo = y_q + bus;
      OP_SUB:  alu_lo = y_q - bus;
      OP_AND:  alu_lo = y_q & bus;
      OP_OR:   alu_lo = y_q | bus;
      OP_SHR:  alu_lo = y_q >> amt;
      OP_SHL:  alu_lo = y_q << amt;
      // Rotates shift a doubled copy so amount 0 needs no special case.
      OP_ROR: begin
        rot    = {y_q, y_q} >> amt;
        alu_lo = rot[WIDTH-1:0];
      end
      OP_ROL: begin
        rot    = {y_q, y_q} << amt;
        alu_lo = rot[2*WIDTH-1:WIDTH];
      end
      OP_NEG:  alu_lo = '0 - bus;
      OP_NOT:  alu_lo = ~bus;
      OP_ADDI: alu_lo = y_q + bus;
`ifdef DP_HILO_EN
      OP_MUL: begin
        prod   = $signed({{WIDTH{y_q[WIDTH-1]}}, y_q}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});
        alu_lo = prod[WIDTH-1:0];
      end
`endif
      default: alu_lo = '0;
    endcase
  end

  always_comb begin
    legal = (op_if.op_code <= OP_OUT);
`ifndef DP_HILO_EN
    if (op_if.op_code == OP_MUL) legal = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rc_d      = rc_q;
    imm_d     = imm_q;
    regs_d    = regs_q;
    y_d       = y_q;
    z_lo_d    = z_lo_q;
    outport_d = outport_q;
    result_d  = result_q;
`ifdef DP_HILO_EN
    z_hi_d    = z_hi_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`endif
    op_if.done   = 1'b0;
    op_if.err    = 1'b0;
    op_if.result = result_q;
    case (state_q)
      IDLE: begin
        if (op_if.op_valid) begin
          op_d    = op_if.op_code;
          ra_d    = op_if.ra_sel;
          rb_d    = op_if.rb_sel;
          rc_d    = op_if.rc_sel;
          imm_d   = op_if.imm;
          state_d = legal ? S_Y : S_ERR;
        end
      end
      S_Y: begin
        if (!is_io) y_d = bus;
        state_d = is_io ? S_WB : S_Z;
      end
      S_Z: begin
        z_lo_d  = alu_lo;
`ifdef DP_HILO_EN
        z_hi_d  = (op_q == OP_MUL) ? prod[2*WIDTH-1:WIDTH] : '0;
`endif
        state_d = S_WB;
      end
      S_WB: begin
        state_d = IDLE;
`ifdef DP_HILO_EN
        if (op_q == OP_MUL) begin
          lo_d    = bus;
          state_d = S_WB2;
        end else
`endif
        begin
          if (op_q == OP_OUT) outport_d = bus;
          else regs_d[ra_q] = bus;
          op_if.done   = 1'b1;
          op_if.result = bus;
          result_d     = bus;
        end
      end
`ifdef DP_HILO_EN
      S_WB2: begin
        hi_d         = bus;
        op_if.done   = 1'b1;
        op_if.result = z_lo_q;
        result_d     = z_lo_q;
        state_d      = IDLE;
      end
`endif
      S_ERR: begin
        op_if.done = 1'b1;
        op_if.err  = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      imm_q     <= '0;
      regs_q    <= '{default: '0};
      y_q       <= '0;
      z_lo_q    <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      result_q  <= '0;
`ifdef DP_HILO_EN
      z_hi_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      imm_q     <= imm_d;
      regs_q    <= regs_d;
      y_q       <= y_d;
      z_lo_q    <= z_lo_d;
      inport_q  <= inport_in;
      outport_q <= outport_d;
      result_q  <= result_d;
`ifdef DP_HILO_EN
      z_hi_q    <= z_hi_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`endif
    end
  end

  assign op_if.op_ready = (state_q == IDLE);
  assign outport_out    = outport_q;
  assign bus_out        = bus;
  assign dbg_data       = regs_q[dbg_sel];
`ifdef DP_HILO_EN
  assign hi_out = hi_q;
  assign lo_out = lo_q;
`endif
endmodule

// File: tb/tb_bus_datapath_core.sv
module tb_bus_datapath_core;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] inport_in = '0;
  logic [31:0] outport_out, bus_out, dbg_data;
  logic [3:0]  dbg_sel = '0;
`ifdef DP_HILO_EN
  logic [31:0] hi_out, lo_out;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [31:0] mregs [16];
  logic [31:0] mout;
  logic [31:0] mres;
  logic [31:0] mhi, mlo;

  bus_datapath_core_if #(.WIDTH(32), .NREGS(16), .IMM_W(19)) op_if ();

  bus_datapath_core #(.WIDTH(32), .NREGS(16), .IMM_W(19)) dut (
    .clk         (clk),
    .clr         (clr),
    .op_if       (op_if),
    .inport_in   (inport_in),
    .outport_out (outport_out),
    .bus_out     (bus_out),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
`ifdef DP_HILO_EN
    ,
    .hi_out      (hi_out),
    .lo_out      (lo_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mout = '0; mres = '0; mhi = '0; mlo = '0;
  endtask

  // Executes one op on the reference state; returns result, err and done latency.
  task automatic model_op(input logic [3:0] op, input int ra, input int rb, input int rc,
                          input logic [18:0] im, input logic [31:0] inp,
                          output logic [31:0] res, output logic e, output int lat);
    logic [31:0] a, b;
    int amt;
    longint p;
    a = (op == 4'd10 && rb == 0) ? 32'd0 : mregs[rb];
    b = (op == 4'd10) ? {{13{im[18]}}, im} : mregs[rc];
    amt = int'(b % 32);
    e = 1'b0; lat = 3; res = '0;
    case (op)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a >> amt;
      4'd5:  res = a << amt;
      4'd6:  res = (amt == 0) ? a : ((a >> amt) | (a << (32 - amt)));
      4'd7:  res = (amt == 0) ? a : ((a << amt) | (a >> (32 - amt)));
      4'd8:  res = 32'd0 - b;
      4'd9:  res = ~b;
      4'd10: res = a + b;
`ifdef DP_HILO_EN
      4'd11: begin
        p = longint'($signed(a)) * longint'($signed(b));
        mlo = p[31:0]; mhi = p[63:32]; res = mlo; lat = 4;
      end
`endif
      4'd12: begin res = inp; lat = 2; end
      4'd13: begin res = mregs[ra]; lat = 2; end
      default: begin e = 1'b1; lat = 1; res = mres; end
    endcase
    if (!e) begin
      mres = res;
      if (op == 4'd13) mout = res;
      else if (op != 4'd11) mregs[ra] = res;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input int ra, input int rb,
                        input int rc, input logic [18:0] im, input logic [31:0] inp);
    logic [31:0] eres;
    logic        eerr;
    int          elat, lat;
    bit          got;
    model_op(op, ra, rb, rc, im, inp, eres, eerr, elat);
    @(negedge clk);
    inport_in       = inp;
    dbg_sel         = 4'(ra);
    op_if.op_valid  = 1'b1;
    op_if.op_code   = op;
    op_if.ra_sel    = 4'(ra);
    op_if.rb_sel    = 4'(rb);
    op_if.rc_sel    = 4'(rc);
    op_if.imm       = im;
    check({tag, ".ready_in"}, 32'(op_if.op_ready), 32'd1);
    @(negedge clk);
    op_if.op_valid = 1'b0;
    op_if.op_code  = 4'($urandom_range(0, 15));
    lat = 1; got = 0;
    while (lat <= 8 && !got) begin
      if (op_if.done) got = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".err"}, 32'(op_if.err), 32'(eerr));
    check({tag, ".result"}, op_if.result, eres);
    @(negedge clk);
    check({tag, ".ready_after"}, 32'(op_if.op_ready), 32'd1);
    check({tag, ".dbg"}, dbg_data, mregs[ra]);
    check({tag, ".outport"}, outport_out, mout);
`ifdef DP_HILO_EN
    check({tag, ".hi"}, hi_out, mhi);
    check({tag, ".lo"}, lo_out, mlo);
`endif
  endtask

  initial begin
    logic [3:0] rop;
    op_if.op_valid = 1'b0;
    op_if.op_code  = '0;
    op_if.ra_sel   = '0;
    op_if.rb_sel   = '0;
    op_if.rc_sel   = '0;
    op_if.imm      = '0;
    model_clear();

    // Reset and dbg sweep
    repeat (2) @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      check($sformatf("reset.r%0d", i), dbg_data, 32'd0);
    end
    check("reset.outport", outport_out, 32'd0);
    check("reset.ready", 32'(op_if.op_ready), 32'd1);
    check("reset.done", 32'(op_if.done), 32'd0);
    check("reset.bus", bus_out, 32'd0);

    // IN / ADD
    run_op("in_r1", 4'd12, 1, 0, 0, '0, 32'h5);
    run_op("in_r2", 4'd12, 2, 0, 0, '0, 32'h7);
    run_op("add_r3", 4'd0, 3, 1, 2, '0, 32'h0);
    check("add_r3.value", mregs[3], 32'h0000000C);

    // ADDI base rule, SUB reading R0 normally
    run_op("in_r0", 4'd12, 0, 0, 0, '0, 32'h100);
    run_op("addi_base", 4'd10, 4, 0, 0, 19'h7FFFF, 32'h0);
    check("addi_base.value", mregs[4], 32'hFFFFFFFF);
    run_op("sub_r0", 4'd1, 5, 0, 1, '0, 32'h0);
    check("sub_r0.value", mregs[5], 32'h000000FB);

    // Shift / rotate / wrap boundaries
    run_op("in_r6", 4'd12, 6, 0, 0, '0, 32'h80000001);
    run_op("in_r7", 4'd12, 7, 0, 0, '0, 32'h1);
    run_op("ror1", 4'd6, 8, 6, 7, '0, 32'h0);
    check("ror1.value", mregs[8], 32'hC0000000);
    run_op("in_r9", 4'd12, 9, 0, 0, '0, 32'd32);
    run_op("shl32", 4'd5, 10, 6, 9, '0, 32'h0);
    check("shl32.value", mregs[10], 32'h80000001);
    run_op("add_wrap", 4'd0, 11, 4, 7, '0, 32'h0);
    check("add_wrap.value", mregs[11], 32'h0);

    // Illegal op then OUT
    run_op("illegal15", 4'd15, 3, 1, 2, '0, 32'h0);
    run_op("out_r3", 4'd13, 3, 0, 0, '0, 32'h0);
    check("out_r3.value", outport_out, 32'h0000000C);

`ifdef DP_HILO_EN
    run_op("in_r12", 4'd12, 12, 0, 0, '0, 32'hFFFFFFFE);
    run_op("in_r13", 4'd12, 13, 0, 0, '0, 32'h3);
    run_op("mul", 4'd11, 14, 12, 13, '0, 32'h0);
    check("mul.hi", hi_out, 32'hFFFFFFFF);
    check("mul.lo", lo_out, 32'hFFFFFFFA);
`else
    run_op("op11_illegal", 4'd11, 3, 1, 2, '0, 32'h0);
`endif

    // Randomized ops against the reference model
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      if (n % 4 == 0) rop = 4'd12;
      run_op($sformatf("rand%0d_op%0d", n, rop), rop, int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             19'($urandom), $urandom);
    end

    // Reset in S_Z of ADD aborts with no done and no write
    @(negedge clk);
    dbg_sel        = 4'd3;
    op_if.op_valid = 1'b1;
    op_if.op_code  = 4'd0;
    op_if.ra_sel   = 4'd3;
    op_if.rb_sel   = 4'd1;
    op_if.rc_sel   = 4'd2;
    @(negedge clk);
    op_if.op_valid = 1'b0;
    check("abort.ready_busy", 32'(op_if.op_ready), 32'd0);
    @(negedge clk);
    check("abort.done_sz", 32'(op_if.done), 32'd0);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    model_clear();
    check("abort.done", 32'(op_if.done), 32'd0);
    check("abort.ready", 32'(op_if.op_ready), 32'd1);
    check("abort.r3", dbg_data, 32'd0);
    check("abort.outport", outport_out, 32'd0);
    @(negedge clk);
    check("abort.no_late_done", 32'(op_if.done), 32'd0);
    check("abort.bus_idle", bus_out, 32'd0);

    run_op("post_in", 4'd12, 2, 0, 0, '0, 32'hA5A5_0001);
    run_op("post_not", 4'd9, 3, 0, 2, '0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
